l2_cache: RTL and testbench

- Second-level, tag-only, set-associative cache model. It sits directly downstream of the L1 cache model in the trace-driven hierarchy simulator.
- It consumes each L1 miss address through a start/done handshake. It then reports hit or miss, updates its tag and LRU state, and maintains a saturating L2 hit counter.
- No data storage; only hit/miss statistics are modelled.

---
 rtl/l2_cache.sv | 135 +++++++++++++
 tb/tb_l2_cache.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// Tag-only set-associative L2 cache model with true-LRU ages and a saturating hit counter.
// Consumes one L1 miss address per start/done handshake; no data storage.
module l2_cache #(
    parameter int way             = 8,
    parameter int block_size_byte = 32,
    parameter int cache_size_byte = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        start,
    output logic [9:0]  hit_count,
    output logic        found_in_cache,
    output logic        updated,
    output logic        done
);
    localparam int set      = cache_size_byte / (block_size_byte * way);
    localparam int offset_w = $clog2(block_size_byte);
    localparam int index_w  = $clog2(set);
    localparam int tag_w    = 32 - index_w - offset_w;
    localparam int way_w    = $clog2(way);

    typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, RESP, WAIT_LOW} state_t;

    state_t state;

    logic [tag_w+index_w-1:0] addr_p0;
    logic [tag_w-1:0]         tag_p0;
    logic [index_w-1:0]       idx_p0;
    logic                     hit_p1;
    logic [way_w-1:0]         tgt_p1;

    logic [tag_w-1:0] tag_mem [set][way];
    logic [way-1:0]   valid   [set];
    logic [way_w-1:0] age     [set][way];

    logic             hit_c;
    logic [way_w-1:0] hit_way_c;
    logic [way_w-1:0] victim_c;
    logic [way_w-1:0] old_age;
    logic             unused_offset;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign unused_offset = ^mem_addr[offset_w-1:0];
    assign tag_p0        = addr_p0[tag_w+index_w-1:index_w];
    assign idx_p0        = addr_p0[index_w-1:0];
    assign old_age       = age[idx_p0][tgt_p1];

    // Lookup: parallel tag compare; victim prefers the lowest invalid way, else the oldest way
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        for (int w = 0; w < way; w++) begin
            if (valid[idx_p0][w] && (tag_mem[idx_p0][w] == tag_p0)) begin
                hit_c     = 1'b1;
                hit_way_c = way_w'(w);
            end
        end
        for (int w = way - 1; w >= 0; w--) begin
            if (age[idx_p0][w] == way_w'(way - 1))
                victim_c = way_w'(w);
        end
        for (int w = way - 1; w >= 0; w--) begin
            if (!valid[idx_p0][w])
                victim_c = way_w'(w);
        end
    end

    // Request capture (p0), lookup result (p1) and tag write
    always_ff @(posedge clk) begin
        if (state == IDLE && start)
            addr_p0 <= mem_addr[31:offset_w];
        if (state == LOOKUP) begin
            hit_p1 <= hit_c;
            tgt_p1 <= hit_c ? hit_way_c : victim_c;
        end
        if (state == UPDATE && !hit_p1)
            tag_mem[idx_p0][tgt_p1] <= tag_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hit_count      <= '0;
            found_in_cache <= 1'b0;
            updated        <= 1'b0;
            done           <= 1'b0;
            for (int s = 0; s < set; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < way; w++)
                    age[s][w] <= way_w'(w);
            end
        end else begin
            updated <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start)
                        state <= LOOKUP;
                end
                LOOKUP: begin
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (!hit_p1)
                        valid[idx_p0][tgt_p1] <= 1'b1;
                    // Ages younger than the target shift up by one; ages stay a permutation
                    for (int w = 0; w < way; w++) begin
                        if (age[idx_p0][w] < old_age)
                            age[idx_p0][w] <= age[idx_p0][w] + 1'b1;
                    end
                    age[idx_p0][tgt_p1] <= '0;
                    if (hit_p1)
                        hit_count <= sat_inc(hit_count);
                    found_in_cache <= hit_p1;
                    state          <= RESP;
                end
                RESP: begin
                    done    <= 1'b1;
                    updated <= 1'b1;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache: cold miss, hits, LRU eviction,
// counter saturation, held start, and reset during an update.
module tb_l2_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        start;
    logic [9:0]  hit_count;
    logic        found_in_cache;
    logic        updated;
    logic        done;

    int checks = 0;
    int errors = 0;

    l2_cache dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .start          (start),
        .hit_count      (hit_count),
        .found_in_cache (found_in_cache),
        .updated        (updated),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction; n counts posedges from the accepting edge until done is seen
    task automatic run_access(input logic [31:0] a, output bit got, output int n);
        @(negedge clk);
        mem_addr = a;
        start    = 1'b1;
        got      = 1'b0;
        n        = 0;
        while (n < 20 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1)
                mem_addr = ~a;
            if (done)
                got = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input bit exp_hit, input string tag);
        bit got;
        int n;
        run_access(a, got, n);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_updated"}, 32'(updated), 32'd1);
        check({tag, "_hit"}, 32'(found_in_cache), 32'(exp_hit));
    endtask

    int lru_k   [10] = '{8, 0, 8, 2, 1, 3, 5, 4, 7, 6};
    bit lru_hit [10] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 0};

    initial begin
        bit got;
        int n;
        int tmo;
        int pulses;

        reset    = 1'b1;
        start    = 1'b0;
        mem_addr = '0;
        do_reset();
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_found", 32'(found_in_cache), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_updated", 32'(updated), 32'd0);

        access(32'h0000_1040, 1'b0, "cold");
        check("cold_count", 32'(hit_count), 32'd0);
        access(32'h0000_1040, 1'b1, "repeat");
        access(32'h0000_105C, 1'b1, "same_block");
        check("repeat_count", 32'(hit_count), 32'd2);

        // Set 2 fills ways 0..7 in order; ages end as 7-w, so k=0 is the first victim
        do_reset();
        access(32'h0000_0060, 1'b0, "set3_fill");
        for (int k = 0; k < 8; k++)
            access(32'h0000_0040 + 32'(k) * 32'h100, 1'b0, $sformatf("fill_k%0d", k));
        for (int i = 0; i < 10; i++)
            access(32'h0000_0040 + 32'(lru_k[i]) * 32'h100, lru_hit[i],
                   $sformatf("lru%0d_k%0d", i, lru_k[i]));
        access(32'h0000_0060, 1'b1, "set3_kept");
        check("lru_count", 32'(hit_count), 32'd5);

        do_reset();
        access(32'h0000_2000, 1'b0, "sat_fill");
        tmo = 0;
        for (int i = 0; i < 1030; i++) begin
            run_access(32'h0000_2000, got, n);
            if (!got)
                tmo++;
        end
        check("sat_timeouts", 32'(tmo), 32'd0);
        check("sat_count", 32'(hit_count), 32'd1023);
        access(32'h0000_2000, 1'b1, "sat_extra");
        check("sat_hold", 32'(hit_count), 32'd1023);

        do_reset();
        @(negedge clk);
        mem_addr = 32'h0000_4000;
        start    = 1'b1;
        pulses   = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done)
                pulses++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_miss", 32'(found_in_cache), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done)
                pulses++;
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_hit", 32'(found_in_cache), 32'd1);
        check("restart_count", 32'(hit_count), 32'd1);
        @(negedge clk);
        start = 1'b0;

        do_reset();
        access(32'h0000_3000, 1'b0, "ru_fill");
        @(negedge clk);
        mem_addr = 32'h0000_3000;
        start    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || updated)
                pulses++;
        end
        check("ru_no_pulse", 32'(pulses), 32'd0);
        check("ru_count", 32'(hit_count), 32'd0);
        access(32'h0000_3000, 1'b0, "ru_after");
        check("ru_after_count", 32'(hit_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
